pcie_x1_tx_vc0_arbiter: RTL and testbench

//  Shares the VC0 transmit TLP port of the x1 PCIe core among NUM_REQ user requesters
//  (DMA write, completer, MSI/message engines). Round-robin arbitration; requests are

---
 rtl/pcie_x1_tx_vc0_arbiter.sv | 145 ++++++++++++++
 tb/tb_pcie_x1_tx_vc0_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_x1_tx_vc0_arbiter.sv
// Round-robin arbiter sharing the x1 PCIe core's VC0 transmit TLP port among NUM_REQ requesters.
// Requests are gated on link state and flow-control credits; the winner's stream is muxed onto tx_*.
module pcie_x1_tx_vc0_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ND_W    = 10
) (
    input  logic                    sys_clk_125,
    input  logic                    rst_n,
    input  logic                    dl_up,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [2*NUM_REQ-1:0]    req_type_i,
    input  logic [ND_W*NUM_REQ-1:0] req_nd_i,
    input  logic [16*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]      req_st_i,
    input  logic [NUM_REQ-1:0]      req_end_i,
    input  logic [NUM_REQ-1:0]      req_nlfy_i,
    output logic [NUM_REQ-1:0]      gnt_o,
    input  logic                    tx_rdy_vc0,
    input  logic [8:0]              tx_ca_ph_vc0,
    input  logic [8:0]              tx_ca_nph_vc0,
    input  logic [8:0]              tx_ca_cplh_vc0,
    input  logic [12:0]             tx_ca_pd_vc0,
    input  logic [12:0]             tx_ca_npd_vc0,
    input  logic [12:0]             tx_ca_cpld_vc0,
    input  logic                    tx_ca_p_recheck_vc0,
    input  logic                    tx_ca_cpl_recheck_vc0,
    output logic                    tx_req_vc0,
    output logic [15:0]             tx_data_vc0,
    output logic                    tx_st_vc0,
    output logic                    tx_end_vc0,
    output logic                    tx_nlfy_vc0,
    output logic                    busy_o
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StReq, StXfer} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   win_q, win_d, rr_ptr_q, rr_ptr_d, rr_next, pick, idx;
    logic               st_seen_q, st_seen_d;
    logic [NUM_REQ-1:0] elig;
    logic               unused_recheck;

    // Eligibility is recomputed from live credits every cycle, so recheck pulses add nothing.
    assign unused_recheck = tx_ca_p_recheck_vc0 ^ tx_ca_cpl_recheck_vc0;

    function automatic logic credit_ok(input logic [1:0] typ, input logic [ND_W-1:0] nd);
        logic [8:0]  ca_h;
        logic [12:0] ca_d;
        unique case (typ)
            2'b01:   begin ca_h = tx_ca_nph_vc0;  ca_d = tx_ca_npd_vc0;  end
            2'b10:   begin ca_h = tx_ca_cplh_vc0; ca_d = tx_ca_cpld_vc0; end
            default: begin ca_h = tx_ca_ph_vc0;   ca_d = tx_ca_pd_vc0;   end
        endcase
        return (ca_h[8] || (ca_h[7:0] != 8'd0)) &&
               ((nd == '0) || ca_d[12] || (32'(ca_d[11:0]) >= 32'(nd)));
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            elig[k] = req_i[k] && dl_up &&
                      credit_ok(req_type_i[2*k +: 2], req_nd_i[ND_W*k +: ND_W]);
        end
    end

    // Scan from the far end so the eligible requester closest to rr_ptr wins.
    always_comb begin
        pick = rr_ptr_q;
        idx  = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            idx = PTR_W'((32'(rr_ptr_q) + 32'(i)) % NUM_REQ);
            if (elig[idx]) pick = idx;
        end
    end

    assign rr_next = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (|elig) begin
                    win_d   = pick;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (!dl_up) begin
                    state_d  = StIdle;
                    rr_ptr_d = rr_next;
                end else if (!elig[win_q]) begin
                    state_d = StIdle;
                end else if (tx_rdy_vc0) begin
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (!dl_up || tx_end_vc0) begin
                    state_d  = StIdle;
                    rr_ptr_d = rr_next;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign st_seen_d = (state_d == StXfer) && (st_seen_q || tx_st_vc0);

    always_ff @(posedge sys_clk_125 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            win_q     <= '0;
            rr_ptr_q  <= '0;
            st_seen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            rr_ptr_q  <= rr_ptr_d;
            st_seen_q <= st_seen_d;
        end
    end

    always_comb begin
        gnt_o = '0;
        if (state_q == StXfer) gnt_o[win_q] = 1'b1;
    end

    // Grant is derived from registered state, so an async reset zeroes the mux at once.
    always_comb begin
        tx_data_vc0 = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_o[k]) tx_data_vc0 = req_data_i[16*k +: 16];
        end
    end

    assign tx_st_vc0   = |(gnt_o & req_st_i);
    assign tx_end_vc0  = |(gnt_o & req_end_i);
    assign tx_nlfy_vc0 = |(gnt_o & req_nlfy_i);
    assign tx_req_vc0  = (state_q == StReq) || ((state_q == StXfer) && !st_seen_q && !tx_st_vc0);
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_pcie_x1_tx_vc0_arbiter.sv
// Bench for pcie_x1_tx_vc0_arbiter: eligibility table, directed corner sequences and a random
// run, all checked against a transaction-level model of the arbitration rules.
module tb_pcie_x1_tx_vc0_arbiter;

    localparam int N   = 3;
    localparam int NDW = 10;
    localparam logic [8:0]  H_INF = 9'h100;
    localparam logic [12:0] D_INF = 13'h1000;

    logic              sys_clk_125 = 1'b0;
    logic              rst_n, dl_up, tx_rdy_vc0;
    logic [N-1:0]      req_i, req_st_i, req_end_i, req_nlfy_i, gnt_o;
    logic [2*N-1:0]    req_type_i;
    logic [NDW*N-1:0]  req_nd_i;
    logic [16*N-1:0]   req_data_i;
    logic [8:0]        tx_ca_ph_vc0, tx_ca_nph_vc0, tx_ca_cplh_vc0;
    logic [12:0]       tx_ca_pd_vc0, tx_ca_npd_vc0, tx_ca_cpld_vc0;
    logic              tx_ca_p_recheck_vc0, tx_ca_cpl_recheck_vc0;
    logic              tx_req_vc0, tx_st_vc0, tx_end_vc0, tx_nlfy_vc0, busy_o;
    logic [15:0]       tx_data_vc0;

    always #4 sys_clk_125 = ~sys_clk_125;

    pcie_x1_tx_vc0_arbiter #(.NUM_REQ(N), .ND_W(NDW)) dut (
        .sys_clk_125(sys_clk_125), .rst_n(rst_n), .dl_up(dl_up), .req_i(req_i),
        .req_type_i(req_type_i), .req_nd_i(req_nd_i), .req_data_i(req_data_i),
        .req_st_i(req_st_i), .req_end_i(req_end_i), .req_nlfy_i(req_nlfy_i), .gnt_o(gnt_o),
        .tx_rdy_vc0(tx_rdy_vc0), .tx_ca_ph_vc0(tx_ca_ph_vc0), .tx_ca_nph_vc0(tx_ca_nph_vc0),
        .tx_ca_cplh_vc0(tx_ca_cplh_vc0), .tx_ca_pd_vc0(tx_ca_pd_vc0),
        .tx_ca_npd_vc0(tx_ca_npd_vc0), .tx_ca_cpld_vc0(tx_ca_cpld_vc0),
        .tx_ca_p_recheck_vc0(tx_ca_p_recheck_vc0), .tx_ca_cpl_recheck_vc0(tx_ca_cpl_recheck_vc0),
        .tx_req_vc0(tx_req_vc0), .tx_data_vc0(tx_data_vc0), .tx_st_vc0(tx_st_vc0),
        .tx_end_vc0(tx_end_vc0), .tx_nlfy_vc0(tx_nlfy_vc0), .busy_o(busy_o)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Transaction-level model: phase 0 idle, 1 requesting core, 2 owning the port.
    int m_phase, m_owner, m_ptr;
    bit m_st_done;
    int sent [N];
    int tlp_len [N];
    bit rearm [N];
    bit nlfy_on [N];
    bit noise;
    int gq [$];
    logic [N-1:0] prev_gnt;

    typedef struct {
        logic [N-1:0]     req;
        logic [2*N-1:0]   typ;
        logic [NDW*N-1:0] nd;
        logic [8:0]       ph, nph, cplh;
        logic [12:0]      pd, npd, cpld;
        logic             dl;
        logic [N-1:0]     exp_gnt;
    } vec_t;
    vec_t vt [13];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit eligible(input int k);
        logic [1:0] t;
        logic [8:0] h;
        logic [12:0] d;
        int nd;
        t  = req_type_i[2*k +: 2];
        nd = int'(req_nd_i[NDW*k +: NDW]);
        if (t == 2'b01)      begin h = tx_ca_nph_vc0;  d = tx_ca_npd_vc0;  end
        else if (t == 2'b10) begin h = tx_ca_cplh_vc0; d = tx_ca_cpld_vc0; end
        else                 begin h = tx_ca_ph_vc0;   d = tx_ca_pd_vc0;   end
        return req_i[k] && dl_up && (h[8] || int'(h[7:0]) >= 1) &&
               (nd == 0 || d[12] || int'(d[11:0]) >= nd);
    endfunction

    task automatic drive_reqs();
        for (int k = 0; k < N; k++) begin
            req_data_i[16*k +: 16] = 16'($urandom);
            req_st_i[k]   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            req_end_i[k]  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            req_nlfy_i[k] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (m_phase == 2) begin
            req_st_i[m_owner]   = (sent[m_owner] == 0);
            req_end_i[m_owner]  = (sent[m_owner] == tlp_len[m_owner] - 1);
            req_nlfy_i[m_owner] = req_end_i[m_owner] && nlfy_on[m_owner];
        end
    endtask

    task automatic check();
        logic [N-1:0] eg;
        logic es, ee, en, er;
        logic [15:0] ed;
        eg = '0; es = 0; ee = 0; en = 0; ed = '0;
        if (m_phase == 2) begin
            eg[m_owner] = 1'b1;
            es = req_st_i[m_owner];
            ee = req_end_i[m_owner];
            en = req_nlfy_i[m_owner];
            ed = req_data_i[16*m_owner +: 16];
        end
        er = (m_phase == 1) || (m_phase == 2 && !m_st_done && !es);
        cmp("gnt", gnt_o, eg);
        cmp("tx_req", tx_req_vc0, er);
        cmp("tx_st", tx_st_vc0, es);
        cmp("tx_end", tx_end_vc0, ee);
        cmp("tx_nlfy", tx_nlfy_vc0, en);
        cmp("tx_data", tx_data_vc0, ed);
        cmp("busy", busy_o, m_phase != 0);
    endtask

    task automatic model_update();
        bit found;
        int k;
        case (m_phase)
            0: begin
                found = 0;
                for (int j = 0; j < N; j++) begin
                    k = (m_ptr + j) % N;
                    if (!found && eligible(k)) begin
                        found = 1; m_owner = k; m_phase = 1;
                    end
                end
            end
            1: begin
                if (!dl_up) begin
                    m_phase = 0; m_ptr = (m_owner + 1) % N;
                end else if (!eligible(m_owner)) begin
                    m_phase = 0;
                end else if (tx_rdy_vc0) begin
                    m_phase = 2; m_st_done = 0;
                end
            end
            default: begin
                k = m_owner;
                if (req_st_i[k]) m_st_done = 1;
                sent[k]++;
                if (!dl_up || req_end_i[k]) begin
                    if (dl_up && !rearm[k]) req_i[k] = 1'b0;
                    m_phase = 0; m_ptr = (k + 1) % N; sent[k] = 0;
                end
            end
        endcase
    endtask

    task automatic step();
        drive_reqs();
        #1;
        check();
        if (gnt_o != '0 && prev_gnt == '0)
            for (int k = 0; k < N; k++) if (gnt_o[k]) gq.push_back(k);
        prev_gnt = gnt_o;
        @(posedge sys_clk_125);
        #1;
        model_update();
        @(negedge sys_clk_125);
    endtask

    task automatic peek();
        drive_reqs();
        #1;
    endtask

    task automatic model_clear();
        m_phase = 0; m_owner = 0; m_ptr = 0; m_st_done = 0; prev_gnt = '0;
        for (int k = 0; k < N; k++) begin
            sent[k] = 0; tlp_len[k] = 4; rearm[k] = 0; nlfy_on[k] = 0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_i = '0; req_type_i = '0; req_nd_i = '0; req_data_i = '0;
        req_st_i = '0; req_end_i = '0; req_nlfy_i = '0;
        dl_up = 1'b1; tx_rdy_vc0 = 1'b1; noise = 0;
        tx_ca_ph_vc0 = H_INF; tx_ca_nph_vc0 = H_INF; tx_ca_cplh_vc0 = H_INF;
        tx_ca_pd_vc0 = D_INF; tx_ca_npd_vc0 = D_INF; tx_ca_cpld_vc0 = D_INF;
        tx_ca_p_recheck_vc0 = 1'b0; tx_ca_cpl_recheck_vc0 = 1'b0;
        model_clear();
        repeat (2) @(negedge sys_clk_125);
        rst_n = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        vt[0]  = '{3'b111, 6'b000000, 30'd0, H_INF, H_INF, H_INF, D_INF, D_INF, D_INF, 1'b1, 3'b001};
        vt[1]  = '{3'b110, 6'b000000, 30'd0, H_INF, H_INF, H_INF, D_INF, D_INF, D_INF, 1'b1, 3'b010};
        vt[2]  = '{3'b001, 6'b000000, {10'd0, 10'd0, 10'd4}, H_INF, H_INF, H_INF,
                   13'd2, D_INF, D_INF, 1'b1, 3'b000};
        vt[3]  = '{3'b011, 6'b001000, {10'd0, 10'd1, 10'd4}, H_INF, H_INF, H_INF,
                   13'd2, D_INF, 13'd1, 1'b1, 3'b010};
        vt[4]  = '{3'b001, 6'b000000, {10'd0, 10'd0, 10'd4}, H_INF, H_INF, H_INF,
                   13'd4, D_INF, D_INF, 1'b1, 3'b001};
        vt[5]  = '{3'b001, 6'b000000, 30'd0, 9'd1, H_INF, H_INF, 13'd0, D_INF, D_INF, 1'b1, 3'b001};
        vt[6]  = '{3'b001, 6'b000000, 30'd0, 9'd0, H_INF, H_INF, D_INF, D_INF, D_INF, 1'b1, 3'b000};
        vt[7]  = '{3'b100, 6'b010000, {10'd1, 10'd0, 10'd0}, 9'd0, 9'd1, 9'd0,
                   13'd0, D_INF, 13'd0, 1'b1, 3'b100};
        vt[8]  = '{3'b100, 6'b110000, {10'd5, 10'd0, 10'd0}, H_INF, H_INF, H_INF,
                   13'd4, D_INF, D_INF, 1'b1, 3'b000};
        vt[9]  = '{3'b111, 6'b000000, 30'd0, H_INF, H_INF, H_INF, D_INF, D_INF, D_INF, 1'b0, 3'b000};
        vt[10] = '{3'b010, 6'b001000, 30'd0, 9'd0, 9'd0, H_INF, 13'd0, 13'd0, 13'd0, 1'b1, 3'b010};
        vt[11] = '{3'b110, 6'b100100, 30'd0, H_INF, 9'd0, H_INF, D_INF, D_INF, D_INF, 1'b1, 3'b100};
        vt[12] = '{3'b001, 6'b000000, {10'd0, 10'd0, 10'd255}, H_INF, H_INF, H_INF,
                   13'h0100, D_INF, D_INF, 1'b1, 3'b001};

        // Eligibility table: each vector starts from reset (rr_ptr = 0).
        for (int i = 0; i < 13; i++) begin
            do_reset();
            req_i = vt[i].req; req_type_i = vt[i].typ; req_nd_i = vt[i].nd; dl_up = vt[i].dl;
            tx_ca_ph_vc0 = vt[i].ph; tx_ca_nph_vc0 = vt[i].nph; tx_ca_cplh_vc0 = vt[i].cplh;
            tx_ca_pd_vc0 = vt[i].pd; tx_ca_npd_vc0 = vt[i].npd; tx_ca_cpld_vc0 = vt[i].cpld;
            step();
            step();
            peek();
            cmp($sformatf("tbl%0d_gnt", i), gnt_o, vt[i].exp_gnt);
            cmp($sformatf("tbl%0d_busy", i), busy_o, vt[i].exp_gnt != '0);
        end

        // Round-robin order with back-to-back requesters.
        do_reset();
        gq.delete();
        for (int k = 0; k < N; k++) rearm[k] = 1;
        req_i = 3'b111;
        repeat (30) step();
        for (int j = 0; j < 4; j++) cmp("rr_order", (gq.size() > j) ? gq[j] : 99, j % 3);

        // Credit-blocked requester is skipped, then served after credits grow.
        do_reset();
        gq.delete();
        req_type_i = 6'b001000; req_nd_i = {10'd0, 10'd1, 10'd4};
        tx_ca_pd_vc0 = 13'd2; tx_ca_cpld_vc0 = D_INF;
        for (int k = 0; k < N; k++) tlp_len[k] = 2;
        req_i = 3'b011;
        repeat (8) step();
        tx_ca_pd_vc0 = 13'd8; tx_ca_p_recheck_vc0 = 1'b1;
        step();
        tx_ca_p_recheck_vc0 = 1'b0;
        repeat (6) step();
        cmp("credit_first", (gq.size() > 0) ? gq[0] : 99, 1);
        cmp("credit_second", (gq.size() > 1) ? gq[1] : 99, 0);

        // tx_rdy withheld: request held, no grant until ready.
        do_reset();
        tx_rdy_vc0 = 1'b0;
        req_i = 3'b001;
        repeat (21) step();
        peek();
        cmp("rdy_hold_req", tx_req_vc0, 1);
        cmp("rdy_hold_gnt", gnt_o, 0);
        tx_rdy_vc0 = 1'b1;
        step();
        peek();
        cmp("rdy_gnt", gnt_o, 3'b001);

        // Single-cycle TLP.
        do_reset();
        tlp_len[0] = 1;
        req_i = 3'b001;
        step();
        step();
        peek();
        cmp("one_st", tx_st_vc0, 1);
        cmp("one_end", tx_end_vc0, 1);
        step();
        peek();
        cmp("one_gnt_clear", gnt_o, 0);
        cmp("one_busy_clear", busy_o, 0);

        // Link drop mid-transfer of requester 1.
        do_reset();
        req_i = 3'b111;
        guard = 0;
        while (!(m_phase == 2 && m_owner == 1 && sent[1] == 1) && guard < 60) begin
            step();
            guard++;
        end
        cmp("dl_reach", guard < 60, 1);
        dl_up = 1'b0;
        step();
        peek();
        cmp("dl_req", tx_req_vc0, 0);
        cmp("dl_gnt", gnt_o, 0);
        cmp("dl_busy", busy_o, 0);
        step();
        req_i[0] = 1'b1;
        dl_up = 1'b1;
        gq.delete();
        guard = 0;
        while (gq.size() == 0 && guard < 20) begin
            step();
            guard++;
        end
        cmp("dl_next", (gq.size() > 0) ? gq[0] : 99, 2);

        // Async reset on the start cycle of requester 0's transfer.
        guard = 0;
        while (!(m_phase == 2 && m_owner == 0 && sent[0] == 0) && guard < 60) begin
            step();
            guard++;
        end
        cmp("rst_reach", guard < 60, 1);
        peek();
        rst_n = 1'b0;
        #1;
        cmp("rst_gnt", gnt_o, 0);
        cmp("rst_req", tx_req_vc0, 0);
        cmp("rst_st", tx_st_vc0, 0);
        cmp("rst_data", tx_data_vc0, 0);
        cmp("rst_busy", busy_o, 0);
        model_clear();
        req_i = '0;
        @(negedge sys_clk_125);
        @(negedge sys_clk_125);
        rst_n = 1'b1;
        req_i = 3'b111;
        gq.delete();
        guard = 0;
        while (gq.size() == 0 && guard < 20) begin
            step();
            guard++;
        end
        cmp("rst_ptr", (gq.size() > 0) ? gq[0] : 99, 0);

        // Random traffic against the model.
        do_reset();
        noise = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!req_i[k] && !(m_phase != 0 && m_owner == k) && $urandom_range(0, 3) == 0) begin
                    req_i[k] = 1'b1;
                    req_type_i[2*k +: 2] = 2'($urandom);
                    req_nd_i[NDW*k +: NDW] = NDW'($urandom_range(0, 8));
                    tlp_len[k] = $urandom_range(1, 4);
                    nlfy_on[k] = ($urandom_range(0, 3) == 0);
                end
            end
            if (m_phase == 2 && $urandom_range(0, 7) == 0) req_i[m_owner] = 1'b0;
            if ($urandom_range(0, 5) == 0) begin
                logic [12:0] v;
                v = ($urandom_range(0, 3) == 0) ? D_INF : 13'($urandom_range(0, 10));
                case ($urandom_range(0, 5))
                    0: tx_ca_ph_vc0 = v[12] ? H_INF : 9'(v[3:0]);
                    1: tx_ca_nph_vc0 = v[12] ? H_INF : 9'(v[3:0]);
                    2: tx_ca_cplh_vc0 = v[12] ? H_INF : 9'(v[3:0]);
                    3: tx_ca_pd_vc0 = v;
                    4: tx_ca_npd_vc0 = v;
                    default: tx_ca_cpld_vc0 = v;
                endcase
            end
            tx_rdy_vc0 = ($urandom_range(0, 2) != 0);
            tx_ca_p_recheck_vc0 = ($urandom_range(0, 9) == 0);
            tx_ca_cpl_recheck_vc0 = ($urandom_range(0, 9) == 0);
            if (dl_up) dl_up = ($urandom_range(0, 199) != 0);
            else dl_up = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
